pool_window_sequencer: RTL



---
 rtl/pool_pkg.sv | 17 +
 rtl/pool_out_fifo.sv | 63 ++++++
 rtl/pool_window_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// Shared types and constants for the 2x2 max-pool window sequencer.
package pool_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int WIN_TL = 0;
  localparam int WIN_TR = 1;
  localparam int WIN_BL = 2;
  localparam int WIN_BR = 3;
  localparam int POOL_K = 2;

endpackage

// File: rtl/pool_out_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and a synchronous clear.
module pool_out_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic          o_valid,
  output logic [W-1:0]  o_data,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A push into a full FIFO is only taken alongside a pop of the head.
  assign w_pop  = i_pop & (r_count != '0);
  assign w_push = i_push & ((r_count != CW'(DEPTH)) | w_pop);

  // Storage, pointers and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_clr) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ptr_inc(r_wr);
      end
      if (w_pop) begin
        r_rd <= ptr_inc(r_rd);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/pool_window_sequencer.sv
// 2x2 max-pool window sequencer: line buffer, latency-tracking valid pipe, credit-gated input.
// Define POOL_SEQ_STATS_EN to add the o_stall_cycles / o_frame_count statistics ports.
module pool_window_sequencer
  import pool_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int IFM_W       = 28,
  parameter int IFM_H       = 28,
  parameter int POOL_LAT    = 4,
  parameter int OFIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [DATA_W-1:0]   i_in_data,
  output logic                o_win_valid,
  output logic [4*DATA_W-1:0] o_win_data,
  input  logic [DATA_W-1:0]   i_pool_result,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [DATA_W-1:0]   o_out_data,
  output logic                o_out_last,
  output logic                o_busy,
  output logic                o_done
`ifdef POOL_SEQ_STATS_EN
  ,
  output logic [31:0]         o_stall_cycles,
  output logic [15:0]         o_frame_count
`endif
);

  localparam int CW         = $clog2(IFM_W);
  localparam int RW         = $clog2(IFM_H);
  localparam int FW         = $clog2(OFIFO_DEPTH + 1);
  localparam int FW1        = FW + 1;
  localparam int LAST_WROW  = (IFM_H / POOL_K) * POOL_K - 1;
  localparam int LAST_WCOL  = (IFM_W / POOL_K) * POOL_K - 1;

  state_t                r_state;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [FW-1:0]         r_in_flight;
  logic [DATA_W-1:0]     r_linebuf [IFM_W];
  logic [DATA_W-1:0]     r_held;
  logic                  r_win_valid;
  logic                  r_win_last;
  logic [4*DATA_W-1:0]   r_win_data;
  logic [POOL_LAT-1:0]   r_vld;
  logic [POOL_LAT-1:0]   r_lst;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_completing;
  logic                  w_last_win;
  logic                  w_credit;
  logic                  w_accept;
  logic                  w_issue;
  logic                  w_frame_end;
  logic                  w_tail;
  logic                  w_fifo_clr;
  logic [CW-1:0]         w_col_m1;
  logic [FW-1:0]         w_fifo_count;
  logic                  w_fifo_valid;
  logic [DATA_W:0]       w_fifo_data;

  // Trailing odd column/row never completes a window, so those pixels fall through unused.
  assign w_completing = r_row[0] & r_col[0] &
                        (r_row <= RW'(LAST_WROW)) & (r_col <= CW'(LAST_WCOL));
  assign w_last_win   = (r_row == RW'(LAST_WROW)) & (r_col == CW'(LAST_WCOL));
  assign w_credit     = ({1'b0, r_in_flight} + {1'b0, w_fifo_count}) < FW1'(OFIFO_DEPTH);
  assign o_in_ready   = (r_state == RUN) & (~w_completing | w_credit);
  assign w_accept     = i_in_valid & o_in_ready;
  assign w_issue      = w_accept & w_completing;
  assign w_frame_end  = (r_row == RW'(IFM_H - 1)) & (r_col == CW'(IFM_W - 1));
  assign w_tail       = r_vld[POOL_LAT-1];
  assign w_fifo_clr   = (r_state == IDLE) & i_start;
  assign w_col_m1     = r_col - CW'(1);

  // Even rows fill the line buffer; odd-row even-column pixels wait in the held register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IFM_W; i++) begin
        r_linebuf[i] <= '0;
      end
      r_held <= '0;
    end else if (w_accept) begin
      if (!r_row[0]) begin
        r_linebuf[r_col] <= i_in_data;
      end else if (!r_col[0]) begin
        r_held <= i_in_data;
      end
    end
  end

  // Window register and the valid/last pipe that mirrors the datapath latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
      r_win_data  <= '0;
      r_vld       <= '0;
      r_lst       <= '0;
    end else begin
      r_win_valid <= w_issue;
      r_win_last  <= w_issue & w_last_win;
      if (w_issue) begin
        r_win_data[WIN_TL*DATA_W +: DATA_W] <= r_linebuf[w_col_m1];
        r_win_data[WIN_TR*DATA_W +: DATA_W] <= r_linebuf[r_col];
        r_win_data[WIN_BL*DATA_W +: DATA_W] <= r_held;
        r_win_data[WIN_BR*DATA_W +: DATA_W] <= i_in_data;
      end
      r_vld[0] <= r_win_valid;
      r_lst[0] <= r_win_last;
      for (int i = 1; i < POOL_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_lst[i] <= r_lst[i-1];
      end
    end
  end

  // Frame FSM with raster counters and the in-flight window count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_in_flight <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_in_flight <= r_in_flight + FW'(w_issue) - FW'(w_tail);
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state     <= RUN;
            r_busy      <= 1'b1;
            r_col       <= '0;
            r_row       <= '0;
            r_in_flight <= '0;
          end
        end
        RUN: begin
          if (w_accept) begin
            if (w_frame_end) begin
              r_state <= DRAIN;
              r_col   <= '0;
              r_row   <= '0;
            end else if (r_col == CW'(IFM_W - 1)) begin
              r_col <= '0;
              r_row <= r_row + RW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        DRAIN: begin
          if ((r_in_flight == '0) && (w_fifo_count == '0)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  pool_out_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (OFIFO_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_fifo_clr),
    .i_push  (w_tail),
    .i_data  ({r_lst[POOL_LAT-1], i_pool_result}),
    .i_pop   (i_out_ready),
    .o_valid (w_fifo_valid),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count)
  );

  assign o_win_valid = r_win_valid;
  assign o_win_data  = r_win_data;
  assign o_out_valid = w_fifo_valid;
  assign o_out_data  = w_fifo_data[DATA_W-1:0];
  assign o_out_last  = w_fifo_data[DATA_W];
  assign o_busy      = r_busy;
  assign o_done      = r_done;

`ifdef POOL_SEQ_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [15:0] r_frame_count;

  // Input stall counter (per frame) and saturating completed-frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= 32'd0;
      r_frame_count  <= 16'd0;
    end else begin
      if (w_fifo_clr) begin
        r_stall_cycles <= 32'd0;
      end else if ((r_state == RUN) && i_in_valid && !o_in_ready) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (r_done && (r_frame_count != 16'hFFFF)) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_frame_count  = r_frame_count;
`endif

endmodule
